// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared types and constants for the tone-synthesis blocks.
//   NOTE_W / ENTRY_W / REST_BIT : layout of a pattern entry {rest, note[5:0]}
//   NOTE_MAX                    : highest note code accepted by base_freq_genx64
//   seq_state_t                 : note_sequencer playback states
//   entry_t                     : packed view of one pattern entry
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int NOTE_W   = 6;
    localparam int ENTRY_W  = 7;
    localparam int REST_BIT = 6;

    localparam logic [NOTE_W-1:0] NOTE_MAX = 6'd63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic              rest;
        logic [NOTE_W-1:0] note;
    } entry_t;

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Tick counter that paces one sequencer step. Counts 0..TICK_DIV-1 while
// running and wraps; flags the cycle where the articulation gap begins and
// the last cycle of the step.
// Ports:
//   clk50mhz   in   system clock
//   rst        in   synchronous reset, active-high
//   i_clear    in   force the counter to 0 on the next edge (has priority)
//   i_run      in   advance the counter this cycle
//   o_gap_hit  out  last gated cycle of the step (never asserted if GAP_CYCLES=0)
//   o_step_hit out  last cycle of the step
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int TICK_DIV   = 12500000,
    parameter int GAP_CYCLES = 1250000
) (
    input  logic clk50mhz,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_gap_hit,
    output logic o_step_hit
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] STEP_AT = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_AT  = TW'(TICK_DIV - GAP_CYCLES - 1);

    logic [TW-1:0] r_tick;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk50mhz) begin
        if (rst || i_clear) begin
            r_tick <= '0;
        end else if (i_run) begin
            r_tick <= (r_tick == STEP_AT) ? '0 : r_tick + TW'(1);
        end
    end

    assign o_step_hit = i_run && (r_tick == STEP_AT);
    // With no gap the gate simply stays up until the step boundary.
    assign o_gap_hit  = i_run && (GAP_CYCLES != 0) && (r_tick == GAP_AT);

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Step sequencer feeding note_in of base_freq_genx64 and gating the square_gen
// output. Plays up to STEPS pattern entries, TICK_DIV cycles each, with the
// gate dropped for the final GAP_CYCLES cycles of every step.
// Ports:
//   clk50mhz  in   system clock, 50 MHz
//   rst       in   synchronous reset, active-high
//   wr_en     in   pattern write strobe
//   wr_addr   in   pattern write address
//   wr_data   in   pattern entry {rest, note[5:0]}
//   last_step in   index of the final step, captured at start
//   loop_en   in   wrap to step 0 after last_step (sampled at each wrap)
//   start     in   pulse: (re)start playback at step 0
//   stop      in   pulse: abort playback (wins over start)
//   note_out  out  note code to the frequency generator (held in IDLE)
//   gate_out  out  1 = tone audible
//   step_idx  out  current step index
//   busy      out  high while playing
//   done      out  one-cycle pulse when a non-looping pattern completes
// -----------------------------------------------------------------------------
module note_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS      = 16,
    parameter int TICK_DIV   = 12500000,
    parameter int GAP_CYCLES = 1250000,
    localparam int AW        = $clog2(STEPS)
) (
    input  logic               clk50mhz,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      last_step,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic [NOTE_W-1:0]  note_out,
    output logic               gate_out,
    output logic [AW-1:0]      step_idx,
    output logic               busy,
    output logic               done
);

    entry_t            r_mem [STEPS];

    seq_state_t        r_state, w_state_nxt;
    logic [AW-1:0]     r_step,  w_step_nxt;
    logic [AW-1:0]     r_last,  w_last_nxt;
    logic [NOTE_W-1:0] r_note,  w_note_nxt;
    logic              r_gate,  w_gate_nxt;
    logic              r_done,  w_done_nxt;

    logic              w_gap_hit;
    logic              w_step_hit;
    logic              w_at_last;
    logic [AW-1:0]     w_rd_addr;
    entry_t            w_rd_entry;

    // NOTE: the pattern RAM has no reset; its contents survive rst and stay
    // undefined until written, which lets it map onto plain RAM.
    always_ff @(posedge clk50mhz) begin
        if (wr_en) begin
            r_mem[wr_addr] <= entry_t'(wr_data);
        end
    end

    // The counter is held at 0 whenever idle and restarts on start/stop, so a
    // fresh step always begins at tick 0.
    step_timer #(
        .TICK_DIV   (TICK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_step_timer (
        .clk50mhz   (clk50mhz),
        .rst        (rst),
        .i_clear    (start || stop || (r_state == IDLE)),
        .i_run      (r_state != IDLE),
        .o_gap_hit  (w_gap_hit),
        .o_step_hit (w_step_hit)
    );

    // Single read port: the entry that would be loaded at the next load event.
    // A write in the same cycle lands after the read, so the old entry plays.
    assign w_at_last  = (r_step == r_last);
    assign w_rd_addr  = (start || w_at_last) ? '0 : r_step + AW'(1);
    assign w_rd_entry = r_mem[w_rd_addr];

    // NOTE: every signal written here gets its hold value first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_last_nxt  = r_last;
        w_note_nxt  = r_note;
        w_gate_nxt  = r_gate;
        w_done_nxt  = 1'b0;

        if (stop) begin
            w_state_nxt = IDLE;
            w_gate_nxt  = 1'b0;
        end else if (start) begin
            w_state_nxt = PLAY;
            w_step_nxt  = '0;
            w_last_nxt  = last_step;
            w_note_nxt  = w_rd_entry.note;
            w_gate_nxt  = ~w_rd_entry.rest;
        end else begin
            unique case (r_state)
                PLAY, GAP: begin
                    if (w_step_hit) begin
                        if (!w_at_last || loop_en) begin
                            w_state_nxt = PLAY;
                            w_step_nxt  = w_rd_addr;
                            w_note_nxt  = w_rd_entry.note;
                            w_gate_nxt  = ~w_rd_entry.rest;
                        end else begin
                            w_state_nxt = IDLE;
                            w_gate_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end else if (w_gap_hit) begin
                        w_state_nxt = GAP;
                        w_gate_nxt  = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_last  <= '0;
            r_note  <= '0;
            r_gate  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_last  <= w_last_nxt;
            r_note  <= w_note_nxt;
            r_gate  <= w_gate_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign note_out = r_note;
    assign gate_out = r_gate;
    assign step_idx = r_step;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Step sequencer that drives the 6-bit `note_in` of `base_freq_genx64`, plus a gate that mutes the `square_gen` output path.
- Plays a programmable pattern of up to STEPS notes at a fixed tempo derived from the 50 MHz clock, with a short articulation gap at the end of each step.
- Sits between the control/host logic, which writes the pattern and issues start/stop, and the tone datapath.

Parameters:
- STEPS, 16, pattern depth; power of two, 2..64.
- TICK_DIV, 12500000, clock cycles per step (250 ms at 50 MHz); must be > GAP_CYCLES+1.
- GAP_CYCLES, 1250000, cycles at the end of each step with gate low (25 ms); may be 0.

Ports:
- clk50mhz  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  log2(STEPS)  pattern write address.
- wr_data  in  7  pattern entry {rest, note[5:0]}; rest=1 means a silent step.
- last_step  in  log2(STEPS)  index of the final step; sampled at start.
- loop_en  in  1  1 = wrap to step 0 after last_step; sampled at each wrap decision.
- start  in  1  single-cycle pulse; begin or restart playback at step 0.
- stop  in  1  single-cycle pulse; abort playback.
- note_out  out  6  note code to the frequency generator.
- gate_out  out  1  1 = tone audible.
- step_idx  out  log2(STEPS)  current step index.
- busy  out  1  high while playing.
- done  out  1  one-cycle pulse when a non-looping pattern completes.

Behaviour:
- Reset values:
  - note_out=0, gate_out=0, step_idx=0, busy=0, done=0.
  - State IDLE; tick counter 0; latched last_step 0.
  - Pattern memory is not cleared by reset. Contents are undefined until written.
- Pattern write:
  - wr_en in cycle N updates mem[wr_addr] at the edge ending N.
  - Writes are accepted in any state, including during reset-free playback.
  - A write to a step is seen when that step is next loaded; a write to the step currently sounding does not change note_out.
- States: IDLE, PLAY, GAP.
- IDLE + start (cycle N): in cycle N+1, state=PLAY, busy=1, step_idx=0, note_out=mem[0].note, gate_out=~mem[0].rest, tick=0, last_step latched.
- Tick counter runs 0..TICK_DIV-1 in PLAY/GAP and increments every cycle.
- PLAY: when tick==TICK_DIV-GAP_CYCLES-1, the next cycle enters GAP with gate_out=0. If GAP_CYCLES=0, GAP is skipped.
- Step boundary at tick==TICK_DIV-1:
  - If step_idx!=latched last_step: step_idx+1, load the new entry into note_out/gate_out, tick=0, state=PLAY.
  - If step_idx==last_step and loop_en=1: step_idx=0, load mem[0], continue.
  - If step_idx==last_step and loop_en=0: IDLE, busy=0, gate_out=0, done=1 for exactly one cycle.
- Step length is therefore exactly TICK_DIV cycles. Gate is high for TICK_DIV-GAP_CYCLES of them, or 0 cycles on a rest step.
- Rest step: note_out still updates to the stored note; gate_out stays 0 for the whole step.
- note_out holds its last value in IDLE (the frequency generator keeps running; the gate mutes it).
- stop in any state: next cycle IDLE, busy=0, gate_out=0, step_idx unchanged, no done pulse.
- start while busy: restart exactly as from IDLE (step 0, tick 0), with no done pulse.
- start and stop in the same cycle: stop wins.
- start and step boundary in the same cycle: start wins.
- last_step=0: a one-step pattern that loops on step 0 when loop_en=1.
- rst mid-playback: all outputs return to their reset values the next cycle; pattern contents are retained.

Decomposition:
- Package synth_pkg:
  - NOTE_W=6, ENTRY_W=7, REST_BIT=6.
  - State enum {IDLE, PLAY, GAP}.
  - Note constants shared with base_freq_genx64 users (e.g. NOTE_MAX=63).
- Sub-module step_timer:
  - Contents: the tick counter, with clear input, and outputs gap_hit and step_hit.
  - Parameterised by TICK_DIV and GAP_CYCLES.
- The FSM and the pattern array stay in note_sequencer.

Test Plan (STEPS=4, TICK_DIV=10, GAP_CYCLES=2):
- Write mem={63,51,39,27} all rest=0, last_step=3, loop_en=0, start → notes 63,51,39,27 each for 10 cycles; gate high 8 cycles then low 2; done pulse 40 cycles after busy rises; busy=0 after.
- Same pattern with loop_en=1 → step_idx sequence 0,1,2,3,0,1; no done pulse; note_out=63 again at cycle 41.
- mem[1]={rest=1,note=51}, play → during step 1 note_out=51, gate_out=0 for all 10 cycles.
- Stop at cycle 15 → cycle 16: busy=0, gate_out=0, step_idx=1, note_out=51 held, no done; start with stop in the same cycle → remains IDLE.
- Start at cycle 25 while busy → next cycle step_idx=0, note_out=63, tick restarted; next boundary 10 cycles later.
- rst at cycle 12 → next cycle all outputs 0, state IDLE; then start → note_out=63 from the retained pattern.
